// File: rtl/huffman_pkg.sv
// huffman_pkg: symbol format shared between the Huffman decoder and its downstream stages
package huffman_pkg;
  localparam int SYM_W = 4;
  localparam int SYM_MIN = -8;
  localparam int SYM_MAX = 7;
endpackage

// File: rtl/delta_sample_fifo.sv
// delta_sample_fifo: first-word-fall-through FIFO; a full FIFO still accepts a push alongside a pop
module delta_sample_fifo #(
  parameter int W = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign count = cnt_q;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout = mem_q[rd_q];
  always_comb begin
    do_pop = pop && !empty && !clear;
    do_push = push && !clear && (!full || do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d = clear ? '0 : wr_q + AW'(do_push);
    rd_d = clear ? '0 : rd_q + AW'(do_pop);
    cnt_d = clear ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/huffman_delta_reconstructor.sv
// huffman_delta_reconstructor: accumulates decoded deltas into saturated samples, tags frame ends
// and buffers them for a valid/ready consumer with almost-full and sticky overflow reporting.
module huffman_delta_reconstructor
  import huffman_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_LEN = 64,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sym_valid,
  input  logic [SYM_W-1:0]    sym_data,
  input  logic                clear,
  output logic                m_valid,
  output logic [SAMPLE_W-1:0] m_data,
  output logic                m_last,
  input  logic                m_ready,
  output logic                almost_full,
  output logic                overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [SAMPLE_W-1:0] SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] SAT_MIN = ~SAT_MAX;
  logic [SAMPLE_W-1:0] pred_q, pred_d, sat;
  logic [SAMPLE_W:0] sum, dout;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [AW:0] count;
  logic overflow_q, overflow_d, last, full, empty;
  always_comb begin
    sum = {pred_q[SAMPLE_W-1], pred_q} + {{(SAMPLE_W+1-SYM_W){sym_data[SYM_W-1]}}, sym_data};
    // the two top bits of the widened sum disagree exactly when the sample range is exceeded
    sat = (sum[SAMPLE_W] != sum[SAMPLE_W-1]) ? (sum[SAMPLE_W] ? SAT_MIN : SAT_MAX) : sum[SAMPLE_W-1:0];
    last = fcnt_q == CW'(FRAME_LEN - 1);
    pred_d = clear ? '0 : !sym_valid ? pred_q : last ? '0 : sat;
    fcnt_d = clear ? '0 : !sym_valid ? fcnt_q : last ? '0 : fcnt_q + CW'(1);
    overflow_d = !clear && (overflow_q || (sym_valid && full && !m_ready));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pred_q <= '0;
      fcnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      pred_q <= pred_d;
      fcnt_q <= fcnt_d;
      overflow_q <= overflow_d;
    end
  delta_sample_fifo #(.W(SAMPLE_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .clear(clear), .push(sym_valid), .pop(m_ready),
    .din({last, sat}), .dout(dout), .count(count), .full(full), .empty(empty)
  );
  assign m_valid = !empty;
  assign m_data = dout[SAMPLE_W-1:0];
  assign m_last = dout[SAMPLE_W];
  assign almost_full = count >= (AW+1)'(FIFO_DEPTH - AFULL_MARGIN);
  assign overflow = overflow_q;
endmodule

// File: tb/tb_huffman_delta_reconstructor.sv
// tb_huffman_delta_reconstructor: directed vectors against two instances (64- and 4-sample frames)
module tb_huffman_delta_reconstructor;
  logic clk = 1'b0, reset = 1'b1, sym_valid = 1'b0, clear = 1'b0, m_ready = 1'b0;
  logic [3:0] sym_data = '0;
  logic m_valid, m_last, almost_full, overflow;
  logic [7:0] m_data;
  logic f_valid, f_last, f_afull, f_ovf;
  logic [7:0] f_data;
  int vectors = 0, errors = 0;

  always #5 clk = ~clk;

  huffman_delta_reconstructor #(.SAMPLE_W(8), .FIFO_DEPTH(8), .FRAME_LEN(64), .AFULL_MARGIN(2)) dut (
    .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_data(sym_data), .clear(clear),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .almost_full(almost_full), .overflow(overflow));

  huffman_delta_reconstructor #(.SAMPLE_W(8), .FIFO_DEPTH(8), .FRAME_LEN(4), .AFULL_MARGIN(2)) dutf (
    .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_data(sym_data), .clear(clear),
    .m_valid(f_valid), .m_data(f_data), .m_last(f_last), .m_ready(m_ready),
    .almost_full(f_afull), .overflow(f_ovf));

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // called at a negedge: presents one symbol for exactly one cycle, returns at the next negedge
  task automatic send(input int d);
    sym_valid = 1'b1;
    sym_data = 4'(d);
    @(negedge clk);
    sym_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_data", int'(m_data), 0);
    chk("rst_last", int'(m_last), 0);
    chk("rst_afull", int'(almost_full), 0);
    chk("rst_ovf", int'(overflow), 0);
    reset = 1'b0;
    @(negedge clk);

    send(3);
    send(4);
    chk("pre_rst_head", int'($signed(m_data)), 3);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", int'(m_valid), 0);
    chk("midrst_data", int'(m_data), 0);
    reset = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    send(2);
    chk("post_rst_valid", int'(m_valid), 1);
    chk("post_rst_data", int'($signed(m_data)), 2);

    do_clear();
    chk("clr_empty", int'(m_valid), 0);
    send(3);
    chk("acc1_valid", int'(m_valid), 1);
    chk("acc1", int'($signed(m_data)), 3);
    send(3);
    chk("acc2", int'($signed(m_data)), 6);
    send(-2);
    chk("acc3", int'($signed(m_data)), 4);
    chk("acc3_last", int'(m_last), 0);

    do_clear();
    for (int i = 0; i < 18; i++) send(7);
    chk("sat_126", int'($signed(m_data)), 126);
    send(7);
    chk("sat_pos", int'($signed(m_data)), 127);
    send(-8);
    chk("sat_pos_down", int'($signed(m_data)), 119);
    do_clear();
    for (int i = 0; i < 17; i++) send(-8);
    chk("sat_neg", int'($signed(m_data)), -128);

    do_clear();
    for (int i = 1; i <= 4; i++) begin
      send(1);
      chk($sformatf("frame_data%0d", i), int'($signed(f_data)), i);
      chk($sformatf("frame_last%0d", i), int'(f_last), i == 4 ? 1 : 0);
    end
    send(1);
    chk("frame2_data", int'($signed(f_data)), 1);
    chk("frame2_last", int'(f_last), 0);

    do_clear();
    m_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      send(1);
      if (i == 5) chk("afull_at5", int'(almost_full), 0);
      if (i == 6) chk("afull_at6", int'(almost_full), 1);
      if (i == 8) chk("ovf_at8", int'(overflow), 0);
    end
    chk("ovf_at9", int'(overflow), 1);
    chk("bp_head_held", int'($signed(m_data)), 1);
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_valid%0d", i), int'(m_valid), 1);
      chk($sformatf("drain_data%0d", i), int'($signed(m_data)), i);
      @(negedge clk);
    end
    chk("drained", int'(m_valid), 0);
    chk("drained_afull", int'(almost_full), 0);
    chk("ovf_sticky", int'(overflow), 1);
    send(1);
    chk("pred_kept", int'($signed(m_data)), 10);

    m_ready = 1'b0;
    send(1);
    send(1);
    chk("q3_head", int'($signed(m_data)), 10);
    clear = 1'b1;
    sym_valid = 1'b1;
    sym_data = 4'd3;
    @(negedge clk);
    clear = 1'b0;
    sym_valid = 1'b0;
    chk("clr_valid", int'(m_valid), 0);
    chk("clr_ovf", int'(overflow), 0);
    m_ready = 1'b1;
    send(-5);
    chk("clr_next", int'($signed(m_data)), -5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/huffman_delta_reconstructor.md
# huffman_delta_reconstructor

Downstream stage of the Huffman decoder FSM. Takes each decoded signed 4-bit delta symbol and adds it to a running predictor. The result is saturated to a SAMPLE_W-bit signed sample and buffered in a small FIFO for a valid/ready consumer. The decoder has no backpressure input, so this block also produces an early-warning `almost_full` and a sticky `overflow` flag.

## Interface
- SAMPLE_W, 8: reconstructed sample width (signed, ≥5).
- FIFO_DEPTH, 8: output FIFO entries; power of two, ≥4.
- FRAME_LEN, 64: samples per frame; predictor restarts at 0 after each frame (≥1).
- AFULL_MARGIN, 2: `almost_full` asserts when occupancy ≥ FIFO_DEPTH−AFULL_MARGIN.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- sym_valid  in  1  one-cycle pulse from decoder, `sym_data` valid.
- sym_data  in  4  signed delta, −8..+7.
- clear  in  1  synchronous flush: predictor, frame counter, FIFO, overflow.
- m_valid  out  1  FIFO non-empty.
- m_data  out  SAMPLE_W  signed sample at FIFO head.
- m_last  out  1  head sample is last of its frame.
- m_ready  in  1  consumer accepts head when m_valid.
- almost_full  out  1  top level gates decoder `svalid` with this.
- overflow  out  1  sticky: a sample was dropped.

## Operation
- On sym_valid: sum = pred + sext(sym_data), computed in SAMPLE_W+1 bits. Saturate to [−2^(SAMPLE_W−1), 2^(SAMPLE_W−1)−1]. Registered pred ← saturated value.
- Frame counter counts accepted symbols 0..FRAME_LEN−1. Sample written with last=1 when count==FRAME_LEN−1; that cycle pred ← 0, counter ← 0.
- FIFO entry = {last, sample}, first-word-fall-through. m_data/m_last driven from the head entry and held stable while m_valid && !m_ready.
- Pop when m_valid && m_ready.
- Push on sym_valid. Allowed if count<FIFO_DEPTH, or if full with a pop in the same cycle; in that case both happen and count is unchanged.
- Full with no pop: sample dropped, overflow ← 1. Predictor and frame counter still advance, so stream alignment is kept.
- Simultaneous push+pop when empty: push occurs, pop ignored (m_valid was 0).
- clear has priority over everything; a sym_valid in the same cycle is ignored. overflow cleared only by clear or reset.
- Must sustain one symbol per cycle, although the decoder emits at most one per 3 cycles.

## Timing
- Reset values: m_valid 0, m_data 0, m_last 0, almost_full 0, overflow 0. Internal: pred 0, frame counter 0, FIFO pointers/count 0, storage zeroed.
- Latency: sym_valid in cycle N → m_valid=1 with the sample in cycle N+1 (FIFO previously empty).
- almost_full, m_valid and overflow are functions of registered state and update the cycle after the causing push/pop.
- Pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits.
- Reset mid-operation: all state returns to reset values immediately; in-flight samples are lost.

## Structure
- Shared package `huffman_pkg`: SYM_W=4, SYM_MIN=−8, SYM_MAX=7. Shared with the decoder.
- Saturation limits derived from SAMPLE_W locally.
- One sub-module: `delta_sample_fifo`, a parameterised synchronous FWFT FIFO with width SAMPLE_W+1. Ports: push, pop, din, dout, count, full, empty, clear.
- Predictor, saturation and frame counter live in the top module.

## Test plan
- Reset: assert reset mid-stream with m_ready=0 → all outputs 0 next edge; next symbol +2 gives m_data=2.
- Accumulate: m_ready=1, symbols +3,+3,−2 → m_data 3,6,4, each one cycle after its sym_valid.
- Saturation (SAMPLE_W=8):
  - 19×(+7) → last output 127.
  - Then −8 → 119.
  - From 0, 17×(−8) → last output −128.
- Frame (FRAME_LEN=4): symbols +1×5 → samples 1,2,3,4 (m_last=1 on 4), then 1 (m_last=0).
- Backpressure (FIFO_DEPTH=8, AFULL_MARGIN=2):
  - m_ready=0, 9 symbols of +1 → almost_full=1 after the 6th push; 9th dropped; overflow=1.
  - Release m_ready → 1..8 in order.
  - Next symbol +1 → 10, since the predictor advanced through the dropped sample.
- Clear: pulse clear with 3 entries queued and a coincident sym_valid → m_valid=0, overflow=0; next symbol −5 → m_data=−5.
